mult_booth_ctrl: RTL and testbench

//   Sequential signed 32x32 multiplier controller. Runs radix-2 Booth recoding over 32 iterations.

---
 rtl/mult_pkg.sv | 35 +++
 rtl/cla.sv | 50 +++++
 rtl/mult_booth_ctrl.sv | 132 +++++++++++++
 tb/tb_mult_booth_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned LAST_ITER = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Product register {A, Q, q_1} shifted right as one unit each iteration.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic             q_1;
  } booth_reg_t;

  function automatic booth_op_t booth_decode(input logic q0, input logic q1);
    case ({q0, q1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cla.sv
// 32-bit carry-lookahead adder: 4-bit groups, group carries resolved by lookahead.
module cla
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic [WIDTH-1:0] s,
  output logic             of
);

  localparam int unsigned GRP  = 4;
  localparam int unsigned NGRP = WIDTH / GRP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [NGRP:0]    gc;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;

  always_comb begin
    g     = x & y;
    p     = x ^ y;
    c     = '0;
    gc    = '0;
    grp_g = '0;
    grp_p = '0;
    gc[0] = c0;
    for (int b = 0; b < NGRP; b++) begin
      grp_p[b] = 1'b1;
      for (int j = 0; j < GRP; j++) begin
        grp_g[b] = g[b*GRP+j] | (p[b*GRP+j] & grp_g[b]);
        grp_p[b] = grp_p[b] & p[b*GRP+j];
      end
      gc[b+1] = grp_g[b] | (grp_p[b] & gc[b]);
    end
    // Carries inside each group ripple from the lookahead group carry-in.
    for (int b = 0; b < NGRP; b++) begin
      c[b*GRP] = gc[b];
      for (int j = 0; j < GRP - 1; j++) begin
        c[b*GRP+j+1] = g[b*GRP+j] | (p[b*GRP+j] & c[b*GRP+j]);
      end
    end
    c[WIDTH] = gc[NGRP];
    s  = p ^ c[WIDTH-1:0];
    of = c[WIDTH] ^ c[WIDTH-1];
  end

endmodule

// File: rtl/mult_booth_ctrl.sv
// Sequential signed 32x32 radix-2 Booth multiplier controller sharing one cla.
// Build option: MULT_HOLD_RESULT_EN keeps result/exception after the done cycle.
module mult_booth_ctrl
  import mult_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic             load_c;
  logic             iter_c;
  logic             finish_c;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m;
  booth_reg_t       pr;
  booth_reg_t       pr_nxt;
  booth_op_t        op_c;
  logic [WIDTH-1:0] add_y_c;
  logic             add_c0_c;
  logic [WIDTH-1:0] sum_c;
  logic             sum_of_c;
  logic [WIDTH-1:0] a_res_c;
  logic             a_msb_c;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    iter_c    = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_MULT) begin
          state_nxt = CALC;
          load_c    = 1'b1;
        end
      end
      CALC: begin
        iter_c = 1'b1;
        if (cnt == CNT_W'(LAST_ITER)) begin
          state_nxt = DONE;
          finish_c  = 1'b1;
        end
      end
      DONE: begin
        if (ctrl_MULT) begin
          state_nxt = CALC;
          load_c    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign op_c     = booth_decode(pr.q[0], pr.q_1);
  assign add_c0_c = (op_c == OP_SUB);
  assign add_y_c  = add_c0_c ? ~m : m;

  cla u_cla (
    .x  (pr.a),
    .y  (add_y_c),
    .c0 (add_c0_c),
    .s  (sum_c),
    .of (sum_of_c)
  );

  // Shift-in uses the true 33-bit sign of A+/-M so M = most-negative works.
  always_comb begin
    a_res_c = (op_c == OP_NOP) ? pr.a : sum_c;
    a_msb_c = (op_c == OP_NOP) ? pr.a[WIDTH-1] : (sum_c[WIDTH-1] ^ sum_of_c);
    pr_nxt.a   = {a_msb_c, a_res_c[WIDTH-1:1]};
    pr_nxt.q   = {a_res_c[0], pr.q[WIDTH-1:1]};
    pr_nxt.q_1 = pr.q[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m   <= '0;
      pr  <= '0;
      cnt <= '0;
    end else if (load_c) begin
      m      <= data_operandA;
      pr.a   <= '0;
      pr.q   <= data_operandB;
      pr.q_1 <= 1'b0;
      cnt    <= '0;
    end else if (iter_c) begin
      pr  <= pr_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      busy           <= (state_nxt == CALC);
      data_resultRDY <= finish_c;
      if (finish_c) begin
        data_result    <= pr_nxt.q;
        data_exception <= (pr_nxt.a != {WIDTH{pr_nxt.q[WIDTH-1]}});
      end else begin
`ifdef MULT_HOLD_RESULT_EN
        data_result    <= data_result;
        data_exception <= data_exception;
`else
        data_result    <= '0;
        data_exception <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Self-checking bench for mult_booth_ctrl: vector table, scoreboard queue, corner sequences.
module tb_mult_booth_ctrl;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  mult_booth_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        e;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t   v;
    longint pa;
    longint pb;
    logic [63:0] p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = 64'(pa * pb);
    v.a = a;
    v.b = b;
    v.r = p[31:0];
    v.e = (p[63:31] != '0) && (p[63:31] != '1);
    return v;
  endfunction

  // Scoreboard: every ready strobe must match the oldest outstanding expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        if (sb.size() == 0) begin
          chk("unexpected_rdy", 64'(data_resultRDY), 64'(0));
        end else begin
          x = sb.pop_front();
          chk("result", 64'(data_result), 64'(x.r));
          chk("exception", 64'(data_exception), 64'(x.e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic e);
    exp_t x;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    x.r = r;
    x.e = e;
    sb.push_back(x);
    tick();
    ctrl_MULT = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  // Ends one step after the edge where the ready strobe must appear.
  task automatic wait_done();
    logic bad;
    bad = 1'b0;
    for (int i = 1; i < 32; i++) begin
      tick();
      if (!busy || data_resultRDY) bad = 1'b1;
    end
    chk("latency_busy_window", 64'(bad), 64'(0));
    tick();
    chk("rdy_at_k32", 64'(data_resultRDY), 64'(1));
    chk("busy_low_at_k32", 64'(busy), 64'(0));
  endtask

  task automatic after_rdy(input logic [31:0] r, input logic e);
    tick();
    chk("rdy_one_cycle", 64'(data_resultRDY), 64'(0));
`ifdef MULT_HOLD_RESULT_EN
    chk("held_result", 64'(data_result), 64'(r));
    chk("held_exception", 64'(data_exception), 64'(e));
`else
    chk("cleared_result", 64'(data_result), 64'(0));
    chk("cleared_exception", 64'(data_exception), 64'(0));
`endif
  endtask

  task automatic vec_add(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic e);
    vec_t v;
    v.a = a; v.b = b; v.r = r; v.e = e;
    vecs.push_back(v);
  endtask

  initial begin
    int rdy_cnt;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vec_add(32'd3,          32'd5,          32'd15,         1'b0);
    vec_add(-32'sd7,        32'd6,          32'hFFFFFFD6,   1'b0);
    vec_add(32'h7FFFFFFF,   32'd2,          32'hFFFFFFFE,   1'b1);
    vec_add(32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1);
    vec_add(32'h80000000,   32'd1,          32'h80000000,   1'b0);
    vec_add(32'h80000000,   32'h80000000,   32'h00000000,   1'b1);
    vec_add(32'h0000FFFF,   32'h0000FFFF,   32'hFFFE0001,   1'b1);
    vec_add(32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0);
    vec_add(32'd0,          32'h12345678,   32'd0,          1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom();
      rb = (i < 3) ? 32'($signed(16'($urandom()))) : $urandom();
      vecs.push_back(model(ra, rb));
    end

    repeat (3) tick();
    chk("reset_result", 64'(data_result), 64'(0));
    chk("reset_exception", 64'(data_exception), 64'(0));
    chk("reset_rdy", 64'(data_resultRDY), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);
      wait_done();
      after_rdy(vecs[i].r, vecs[i].e);
    end

    // Start pulse mid-op and operand changes must be ignored.
    start_op(32'd3, 32'd5, 32'd15, 1'b0);
    repeat (9) tick();
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    tick();
    ctrl_MULT     = 1'b0;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 32'h01234567;
    repeat (21) tick();
    tick();
    chk("ignored_start_rdy", 64'(data_resultRDY), 64'(1));
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY || busy) rdy_cnt++;
    end
    chk("no_second_op", 64'(rdy_cnt), 64'(0));

    // Reset mid-calculation aborts without a ready strobe.
    start_op(32'd11, 32'd13, 32'd143, 1'b0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_result", 64'(data_result), 64'(0));
    chk("abort_exception", 64'(data_exception), 64'(0));
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (data_resultRDY) rdy_cnt++;
    end
    chk("abort_no_rdy", 64'(rdy_cnt), 64'(0));

    // Back-to-back: second start in the DONE cycle.
    start_op(32'd100, -32'sd3, 32'hFFFFFED4, 1'b0);
    wait_done();
    start_op(32'h00010000, 32'h00008000, 32'h80000000, 1'b1);
    chk("b2b_rdy_dropped", 64'(data_resultRDY), 64'(0));
    wait_done();
    after_rdy(32'h80000000, 1'b1);

    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
